// File: rtl/fft_stage_sequencer_if.sv
// Handshake and strobe bundle between an FFT stage sequencer and its requester/address generator.
// With FFT_SEQ_STALL_EN defined the bundle also carries a stall input to the sequencer.
interface fft_stage_sequencer_if #(
  parameter int NUMSTAGES = 5
) ();
  localparam int CNT_W = NUMSTAGES - 2;

  logic             start;
  logic             ready;
  logic             busy;
  logic [CNT_W-1:0] counter_r;
  logic [2:0]       stage_num_r;
  logic             rd_en;
  logic             wr_en;
  logic [CNT_W-1:0] wr_counter;
  logic [2:0]       wr_stage;
  logic             stage_done;
  logic             done;
`ifdef FFT_SEQ_STALL_EN
  logic             stall;

  modport master (
    output start, stall,
    input  ready, busy, counter_r, stage_num_r, rd_en, wr_en,
    input  wr_counter, wr_stage, stage_done, done
  );

  modport slave (
    input  start, stall,
    output ready, busy, counter_r, stage_num_r, rd_en, wr_en,
    output wr_counter, wr_stage, stage_done, done
  );
`else
  modport master (
    output start,
    input  ready, busy, counter_r, stage_num_r, rd_en, wr_en,
    input  wr_counter, wr_stage, stage_done, done
  );

  modport slave (
    input  start,
    output ready, busy, counter_r, stage_num_r, rd_en, wr_en,
    output wr_counter, wr_stage, stage_done, done
  );
`endif
endinterface

// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly sequencer for an in-place radix-2 FFT: read strobes per stage, a drain gap, and a
// PIPE_LAT-delayed write strobe. Optional FFT_SEQ_STALL_EN adds a stall input that freezes the sequence.
module fft_stage_sequencer #(
  parameter int NUMSTAGES  = 5,
  parameter int NUMSAMPLES = 32,
  parameter int PIPE_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_stage_sequencer_if.slave bus
);
  localparam int CNT_W = NUMSTAGES - 2;
  localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUMSAMPLES / 4 - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_LAT - 1);
  localparam logic [2:0]       STG_LAST = 3'(NUMSTAGES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [2:0]                      stg_q, stg_d;
  logic [DRN_W-1:0]                drn_q, drn_d;
  logic [PIPE_LAT-1:0]             wen_q, wen_d;
  logic [PIPE_LAT-1:0][CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [PIPE_LAT-1:0][2:0]        wstg_q, wstg_d;

  logic stall;
  logic hold;
  logic rd_en;
  logic stage_done;
  logic done;

`ifdef FFT_SEQ_STALL_EN
  assign stall = bus.stall;
`else
  assign stall = 1'b0;
`endif
  // stall has no effect while idle, so a start is still accepted
  assign hold = stall && (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stg_d      = stg_q;
    drn_d      = drn_q;
    rd_en      = 1'b0;
    stage_done = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
          stg_d   = '0;
        end
      end
      RUN: begin
        if (!hold) begin
          rd_en = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            drn_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (!hold) begin
          if (drn_q == DRN_LAST) begin
            stage_done = 1'b1;
            drn_d      = '0;
            if (stg_q == STG_LAST) begin
              done    = 1'b1;
              stg_d   = '0;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              stg_d   = stg_q + 3'd1;
              state_d = RUN;
            end
          end else begin
            drn_d = drn_q + DRN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write-side delay line: {rd_en, counter, stage} shifted once per non-stalled cycle
  always_comb begin
    wen_d  = wen_q;
    wcnt_d = wcnt_q;
    wstg_d = wstg_q;
    if (!hold) begin
      wen_d[0]  = rd_en;
      wcnt_d[0] = cnt_q;
      wstg_d[0] = stg_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        wen_d[i]  = wen_q[i-1];
        wcnt_d[i] = wcnt_q[i-1];
        wstg_d[i] = wstg_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stg_q   <= '0;
      drn_q   <= '0;
      wen_q   <= '0;
      wcnt_q  <= '0;
      wstg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stg_q   <= stg_d;
      drn_q   <= drn_d;
      wen_q   <= wen_d;
      wcnt_q  <= wcnt_d;
      wstg_q  <= wstg_d;
    end
  end

  assign bus.ready       = (state_q == IDLE);
  assign bus.busy        = (state_q == RUN) || (state_q == DRAIN);
  assign bus.counter_r   = cnt_q;
  assign bus.stage_num_r = stg_q;
  assign bus.rd_en       = rd_en;
  assign bus.wr_en       = wen_q[PIPE_LAT-1] && !hold;
  assign bus.wr_counter  = wcnt_q[PIPE_LAT-1];
  assign bus.wr_stage    = wstg_q[PIPE_LAT-1];
  assign bus.stage_done  = stage_done;
  assign bus.done        = done;
endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
Generates the per-stage butterfly count and stage number that drive the FFT address generator (counter_r / stage_num_r inputs of address_control). It also generates the matching read and write strobes for the two-bank sample memory. The block runs one complete NUMSTAGES-stage, NUMSAMPLES-point transform per start request. Between stages it inserts a drain gap so that every write from stage s lands before stage s+1 begins reading.

Parameters:
- NUMSTAGES, 5, log2 of transform size; number of butterfly stages.
- NUMSAMPLES, 32, points per transform; must equal 2**NUMSTAGES.
- PIPE_LAT, 2, read-to-write latency of the butterfly datapath in cycles; must be >= 1.

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request a transform; accepted only when ready=1.
- ready, output, 1, high in IDLE only.
- busy, output, 1, high in RUN and DRAIN.
- counter_r, output, NUMSTAGES-2, butterfly-pair read index within the current stage.
- stage_num_r, output, 3, current stage, 0..NUMSTAGES-1.
- rd_en, output, 1, read strobe; counter_r/stage_num_r are valid read addresses this cycle.
- wr_en, output, 1, write strobe: rd_en delayed by PIPE_LAT cycles.
- wr_counter, output, NUMSTAGES-2, counter_r delayed by PIPE_LAT cycles.
- wr_stage, output, 3, stage_num_r delayed by PIPE_LAT cycles.
- stage_done, output, 1, one-cycle pulse on the last DRAIN cycle of each stage.
- done, output, 1, one-cycle pulse when the final stage has fully drained.

Behaviour:
- Reset:
  - state=IDLE; ready=1.
  - busy, rd_en, wr_en, stage_done, done = 0.
  - counter_r, stage_num_r, wr_counter, wr_stage = 0.
  - All PIPE_LAT delay-line stages cleared.
  - rst overrides everything, including mid-transform; the aborted transform produces no further wr_en.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 moves to RUN next cycle with counter_r=0, stage_num_r=0.
  - start while busy is ignored; it is neither queued nor an error.
- RUN:
  - rd_en=1 every cycle.
  - counter_r increments by 1 per cycle, from 0 to 2**(NUMSTAGES-2)-1 (0..7 at default).
  - At terminal count, next cycle goes to DRAIN; counter_r wraps to 0 on that transition.
  - Each stage has exactly 2**(NUMSTAGES-2) RUN cycles.
- DRAIN:
  - rd_en=0; lasts exactly PIPE_LAT cycles, counted by an internal drain counter.
  - stage_done pulses on the last DRAIN cycle.
  - If stage_num_r < NUMSTAGES-1: stage_num_r increments and the next cycle is RUN.
  - Else: done pulses on the same cycle as stage_done; next cycle is IDLE with stage_num_r=0 and counter_r=0.
- Write path:
  - Fed by a PIPE_LAT-deep shift register of {rd_en, counter_r, stage_num_r}.
  - The final write of each stage occurs on the last DRAIN cycle, the same cycle as stage_done.
  - wr_en and rd_en are never both high for different stages.
- Latency:
  - First rd_en is the cycle after start is accepted.
  - done occurs NUMSTAGES*(2**(NUMSTAGES-2)+PIPE_LAT) cycles after the first rd_en cycle (50 at defaults).
- Widths:
  - counter_r wraps modulo 2**(NUMSTAGES-2).
  - stage_num_r is fixed at 3 bits; NUMSTAGES > 7 is unsupported.
- Back-to-back: start may be asserted on the done cycle. It is ignored because ready=0 that cycle; ready rises the following cycle.

Optional Feature:
- Macro: FFT_SEQ_STALL_EN.
- Defined:
  - Adds an input stall (1 bit).
  - While stall=1 in RUN or DRAIN, the FSM, counter_r, drain counter and delay line all hold.
  - rd_en and wr_en are forced 0 during stall.
  - stage_done and done cannot assert while stalled.
  - Held values resume unchanged when stall deasserts.
  - stall is ignored in IDLE.
- Not defined: no stall port; the sequencer free-runs as described above.

Test Plan:
- Reset then single start (defaults) -> stage 0 counter_r 0..7 over 8 cycles, 2 DRAIN cycles, repeated through stages 0..4; done pulses exactly 50 cycles after first rd_en; ready returns high next cycle.
- Check write path over the same run -> wr_en/wr_counter/wr_stage equal rd_en/counter_r/stage_num_r exactly 2 cycles earlier; 40 wr_en pulses total; last one coincides with done.
- start held high continuously -> transforms run back-to-back with exactly one IDLE cycle between done and the next stage-0 rd_en.
- start pulsed at stage 2, counter 3 -> ignored; no change in sequence; done at cycle 50 only.
- rst asserted at stage 3, counter 5 -> next cycle all outputs 0, ready=1; no wr_en afterwards; a fresh start then completes normally.
- With FFT_SEQ_STALL_EN: stall high 4 cycles at stage 1, counter 6 -> counter_r holds 6 and rd_en/wr_en are 0 for those 4 cycles; done arrives at cycle 54.
